// File: rtl/clk_div_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor.
// Pure declarations: no latency, no backpressure.
package clk_div_mon_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int MATCH_W = 4;

  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max_v);
    return (v >= max_v) ? max_v : v + 1;
  endfunction

endpackage

// File: rtl/clk_div_monitor_if.sv
// Divided-clock sample input and measurement/strobe outputs of clk_div_monitor.
// Wiring only: no latency, no backpressure (outputs are free-running pulses/levels).
interface clk_div_monitor_if #(
  parameter int CNT_W = 8
);
  logic             div_clk_in;
  logic             rise_stb;
  logic             fall_stb;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_vld;
  logic             locked;
  logic             err;

  modport master (
    output div_clk_in,
    input  rise_stb, fall_stb, period, high_time, period_vld, locked, err
  );

  modport slave (
    input  div_clk_in,
    output rise_stb, fall_stb, period, high_time, period_vld, locked, err
  );
endinterface

// File: rtl/clk_div_monitor_sync_edge_det.sv
// Synchronizer chain plus previous-value flop; combinational rise/fall of the synced level.
// Latency SYNC_STAGES cycles to the edge outputs; no backpressure.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= w_s;
    end
  end

  assign o_rise = w_s & ~r_prev;
  assign o_fall = ~w_s & r_prev;
endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: edge strobes, period/high-time measurement, lock and error detection.
// Strobes SYNC_STAGES+1 cycles after input edge; no backpressure. Duty check: CLK_DIV_MON_DUTY_CHECK_EN.
module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int EXP_DIV     = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4
) (
  input logic clk_in,
  input logic rst,
  clk_div_monitor_if.slave mon
);
  localparam int unsigned      CNT_MAX_I = 2**CNT_W - 1;
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(CNT_MAX_I - 1);

  logic               w_rise, w_fall, w_timeout, w_exp_ok, w_duty_ok, w_match, w_err_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [MATCH_W-1:0] w_match_inc, w_match_nxt;
  state_t             w_state_nxt;

  logic               r_rise_stb, r_fall_stb, r_period_vld, r_locked, r_err;
  logic [CNT_W-1:0]   r_cnt, r_period, r_high_time;
  logic [MATCH_W-1:0] r_match;
  state_t             r_state;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .i_async(mon.div_clk_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // cnt+1 is both the next count and the measured length ending this cycle.
  assign w_cnt_inc   = CNT_W'(sat_inc(32'(r_cnt), CNT_MAX_I));
  assign w_timeout   = ~w_rise & (r_cnt == CNT_PRE);
  assign w_exp_ok    = (w_cnt_inc == CNT_W'(EXP_DIV));
  assign w_match_inc = r_match + 1'b1;

`ifdef CLK_DIV_MON_DUTY_CHECK_EN
  assign w_duty_ok = (r_high_time == CNT_W'(EXP_DIV / 2)) ||
                     (r_high_time == CNT_W'((EXP_DIV + 1) / 2));
`else
  assign w_duty_ok = 1'b1;
`endif

  assign w_match = w_exp_ok & w_duty_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match;
    w_err_nxt   = 1'b0;
    case (r_state)
      SEARCH: begin
        if (w_rise) begin
          w_state_nxt = TRACK;
          w_match_nxt = '0;
        end
      end
      TRACK: begin
        if (w_rise) begin
          if (w_match) begin
            w_match_nxt = w_match_inc;
            if (w_match_inc == MATCH_W'(LOCK_CNT)) w_state_nxt = LOCKED;
          end else begin
            w_match_nxt = '0;
          end
        end else if (w_timeout) begin
          w_state_nxt = SEARCH;
          w_match_nxt = '0;
          w_err_nxt   = 1'b1;
        end
      end
      LOCKED: begin
        if (w_rise) begin
          if (!w_match) begin
            w_state_nxt = TRACK;
            w_match_nxt = '0;
            w_err_nxt   = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt = SEARCH;
          w_match_nxt = '0;
          w_err_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = SEARCH;
        w_match_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state <= SEARCH;
      r_match <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_match <= w_match_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_cnt        <= '0;
      r_rise_stb   <= 1'b0;
      r_fall_stb   <= 1'b0;
      r_period     <= '0;
      r_high_time  <= '0;
      r_period_vld <= 1'b0;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_cnt        <= w_rise ? '0 : w_cnt_inc;
      r_rise_stb   <= w_rise;
      r_fall_stb   <= w_fall;
      if (w_rise) r_period    <= w_cnt_inc;
      if (w_fall) r_high_time <= w_cnt_inc;
      // The rise that leaves SEARCH closes an unknown-length interval.
      r_period_vld <= w_rise & (r_state != SEARCH);
      r_locked     <= (w_state_nxt == LOCKED);
      r_err        <= w_err_nxt;
    end
  end

  assign mon.rise_stb   = r_rise_stb;
  assign mon.fall_stb   = r_fall_stb;
  assign mon.period     = r_period;
  assign mon.high_time  = r_high_time;
  assign mon.period_vld = r_period_vld;
  assign mon.locked     = r_locked;
  assign mon.err        = r_err;
endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor at EXP_DIV=4, CNT_W=8, SYNC_STAGES=2, LOCK_CNT=4.
module tb_clk_div_monitor;
  logic clk;
  logic rst;

  clk_div_monitor_if #(.CNT_W(8)) ifc ();

  clk_div_monitor #(
    .EXP_DIV    (4),
    .CNT_W      (8),
    .SYNC_STAGES(2),
    .LOCK_CNT   (4)
  ) dut (
    .clk_in(clk),
    .rst   (rst),
    .mon   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_rise = 0, n_vld = 0, n_err = 0;
  int vld_period = 0, vld_ht = 0, vld_locked = 0, vld_err = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    if (ifc.rise_stb) n_rise++;
    if (ifc.err) n_err++;
    if (ifc.period_vld) begin
      n_vld++;
      vld_period = int'(ifc.period);
      vld_ht     = int'(ifc.high_time);
      vld_locked = int'(ifc.locked);
      vld_err    = int'(ifc.err);
    end
  endtask

  task automatic drive_period(input int h, input int l);
    for (int i = 0; i < h + l; i++) begin
      ifc.div_clk_in = (i < h);
      tick();
      sample();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rise"},   int'(ifc.rise_stb),   0);
    chk({tag, "_fall"},   int'(ifc.fall_stb),   0);
    chk({tag, "_period"}, int'(ifc.period),     0);
    chk({tag, "_high"},   int'(ifc.high_time),  0);
    chk({tag, "_vld"},    int'(ifc.period_vld), 0);
    chk({tag, "_locked"}, int'(ifc.locked),     0);
    chk({tag, "_err"},    int'(ifc.err),        0);
  endtask

  initial begin
    int base_vld, base_rise, base_err, err_tick;

    // Reset with divided clock low.
    rst = 1'b1;
    ifc.div_clk_in = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // First rise: strobe exactly three edges after the new level is driven.
    ifc.div_clk_in = 1'b1;
    tick();
    tick();
    chk("first_rise_early", int'(ifc.rise_stb), 0);
    ifc.div_clk_in = 1'b0;
    tick();
    chk("first_rise_lat", int'(ifc.rise_stb), 1);
    chk("first_rise_novld", int'(ifc.period_vld), 0);
    tick();

    // Clean divide-by-4: lock on the 4th measured period.
    for (int i = 1; i <= 4; i++) begin
      drive_period(2, 2);
      chk("div4_nvld", n_vld, i);
      chk("div4_period", vld_period, 4);
      chk("div4_high", vld_ht, 2);
      chk("div4_locked", vld_locked, (i == 4) ? 1 : 0);
    end
    chk("div4_no_err", n_err, 0);
    chk("div4_nrise", n_rise, 4);

    // One 5-cycle period while locked.
    drive_period(3, 2);
    chk("long_prev_ok", vld_locked, 1);
    drive_period(2, 2);
    chk("long_period", vld_period, 5);
    chk("long_high", vld_ht, 3);
    chk("long_err", vld_err, 1);
    chk("long_unlock", vld_locked, 0);
    chk("long_nerr", n_err, 1);
    for (int i = 1; i <= 4; i++) begin
      drive_period(2, 2);
      chk("relock_locked", vld_locked, (i == 4) ? 1 : 0);
    end
    chk("relock_nerr", n_err, 1);

    // Hold low: single timeout error when cnt saturates.
    base_err = n_err;
    err_tick = -1;
    ifc.div_clk_in = 1'b0;
    for (int j = 1; j <= 300; j++) begin
      tick();
      if (ifc.err && err_tick < 0) err_tick = j;
      sample();
    end
    chk("timeout_tick", err_tick, 254);
    chk("timeout_once", n_err - base_err, 1);
    chk("timeout_locked", int'(ifc.locked), 0);

    // Back in SEARCH: next rise gives no period_vld.
    base_vld = n_vld;
    base_rise = n_rise;
    drive_period(2, 2);
    chk("search_rise", n_rise - base_rise, 1);
    chk("search_novld", n_vld - base_vld, 0);
    for (int i = 1; i <= 4; i++) begin
      drive_period(2, 2);
      chk("resrch_period", vld_period, 4);
      chk("resrch_locked", vld_locked, (i == 4) ? 1 : 0);
    end

    // 1-high/3-low waveform while locked.
    base_err = n_err;
    for (int i = 1; i <= 4; i++) drive_period(1, 3);
    chk("duty_period", vld_period, 4);
    chk("duty_high", vld_ht, 1);
`ifdef CLK_DIV_MON_DUTY_CHECK_EN
    chk("duty_locked", int'(ifc.locked), 0);
    chk("duty_err", n_err - base_err, 1);
`else
    chk("duty_locked", int'(ifc.locked), 1);
    chk("duty_err", n_err - base_err, 0);
`endif

    // Reset mid-period with div_clk_in high, then re-sync.
    drive_period(2, 2);
    ifc.div_clk_in = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_all_zero("midrst");
    rst = 1'b0;
    base_vld = n_vld;
    base_rise = n_rise;
    drive_period(2, 2);
    chk("midrst_rise", n_rise - base_rise, 1);
    chk("midrst_novld", n_vld - base_vld, 0);
    for (int i = 1; i <= 4; i++) begin
      drive_period(2, 2);
      chk("midrst_locked", vld_locked, (i == 4) ? 1 : 0);
    end
    chk("midrst_final", int'(ifc.locked), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
